// File: rtl/sram_pkg.sv
// Shared constants for the two-port SRAM Wishbone arbiter.
// State encoding, default burst limit and word-address width.
package sram_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_G0     = 2'd1,
    ARB_G1     = 2'd2,
    ARB_SWITCH = 2'd3
  } arb_state_t;

  localparam int SRAM_MAX_BURST = 8;
  localparam int SRAM_AW        = 30;

  // Grant state for a port id (0 -> G0, 1 -> G1)
  function automatic arb_state_t gnt_state(input logic port);
    return port ? ARB_G1 : ARB_G0;
  endfunction

endpackage

// File: rtl/sram_arb_mux.sv
// Master-to-slave mux and ack steering for the SRAM arbiter.
// Purely combinational; gnt is one-hot or zero. With no grant every
// slave-side output is 0 and no ack reaches any master.
module sram_arb_mux
  import sram_pkg::*;
#(
  parameter int AW        = SRAM_AW,
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]          gnt,
  input  logic [NUM_PORTS-1:0][AW-1:0]  m_adr,
  input  logic [NUM_PORTS-1:0][31:0]    m_dat,
  input  logic [NUM_PORTS-1:0][3:0]     m_sel,
  input  logic [NUM_PORTS-1:0]          m_we,
  input  logic [NUM_PORTS-1:0]          m_stb,
  input  logic [NUM_PORTS-1:0]          m_cyc,
  input  logic                          s_ack,
  output logic [NUM_PORTS-1:0]          m_ack,
  output logic [AW-1:0]                 s_adr,
  output logic [31:0]                   s_dat,
  output logic [3:0]                    s_sel,
  output logic                          s_we,
  output logic                          s_stb,
  output logic                          s_cyc
);

  // AND-OR select: one-hot grant means at most one term is live
  always_comb begin
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    s_we  = 1'b0;
    s_stb = 1'b0;
    s_cyc = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      s_adr = s_adr | ({AW{gnt[i]}} & m_adr[i]);
      s_dat = s_dat | ({32{gnt[i]}} & m_dat[i]);
      s_sel = s_sel | ({4{gnt[i]}}  & m_sel[i]);
      s_we  = s_we  | (gnt[i] & m_we[i]);
      s_stb = s_stb | (gnt[i] & m_stb[i]);
      s_cyc = s_cyc | (gnt[i] & m_cyc[i]);
    end
  end

  // Ack only to the granted port, and only while its stb is up
  assign m_ack = gnt & m_stb & {NUM_PORTS{s_ack}};

endmodule

// File: rtl/sram_arb_wb.sv
// Two-port Wishbone classic arbiter in front of a single SRAM slave.
// Registered round-robin grant, burst limit forcing re-arbitration on an
// ack boundary, and one dead cycle (SWITCH) between owners.
// Optional macro SRAM_ARB_PRIO_EN: port 0 gets fixed priority and only
// port 1 is subject to the burst limit.
module sram_arb_wb
  import sram_pkg::*;
#(
  parameter int MAX_BURST = SRAM_MAX_BURST,  // 1..255
  parameter int AW        = SRAM_AW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [31:0]   m1_dat_i,
  output logic [31:0]   m0_dat_o,
  output logic [31:0]   m1_dat_o,
  input  logic [3:0]    m0_sel_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m0_we_i,
  input  logic          m1_we_i,
  input  logic          m0_stb_i,
  input  logic          m1_stb_i,
  input  logic          m0_cyc_i,
  input  logic          m1_cyc_i,
  output logic          m0_ack_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  input  logic [31:0]   s_dat_i,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_stb_o,
  output logic          s_cyc_o,
  input  logic          s_ack_i,
  output logic [1:0]    gnt_o
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;       // port id served most recently
  logic [7:0] cnt, cnt_nxt;         // contested acks in current grant
  logic [1:0] req, gnt, ack;
  logic       own, own_cyc, oth_req, lim_en, burst_hit, expire;
  logic       pick_first, pick_second;
  logic       pick_port, pick_any;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  // Current owner id; meaningful only in G0/G1
  assign own     = (state == ARB_G1);
  assign own_cyc = own ? m1_cyc_i : m0_cyc_i;
  assign oth_req = own ? req[0] : req[1];

`ifdef SRAM_ARB_PRIO_EN
  // Port 0 is never preempted; port 1 yields after MAX_BURST acks
  assign lim_en      = own;
  assign pick_first  = 1'b0;
`else
  assign lim_en      = 1'b1;
  assign pick_first  = ~last;
`endif
  assign pick_second = ~pick_first;

  // Preferred port first, otherwise the other one; used in IDLE and SWITCH
  assign pick_port = req[pick_first] ? pick_first : pick_second;
  assign pick_any  = |req;

  // ack only ever carries the granted port's forwarded ack
  assign burst_hit = (|ack) & oth_req & lim_en;
  assign expire    = burst_hit & (cnt == 8'(MAX_BURST - 1));

  // State, last-served and burst counter registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: arbitration in IDLE/SWITCH, exit detection in G0/G1
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    unique case (state)
      ARB_IDLE, ARB_SWITCH: begin
        state_nxt = pick_any ? gnt_state(pick_port) : ARB_IDLE;
      end
      ARB_G0, ARB_G1: begin
        // cyc drop and burst expiry in the same cycle form one exit
        if (!own_cyc || expire) begin
          state_nxt = ARB_SWITCH;
          last_nxt  = own;
          cnt_nxt   = '0;
        end else if (burst_hit) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: one-hot grant decoded from state
  always_comb begin
    gnt = {state == ARB_G1, state == ARB_G0};
  end

  assign gnt_o = gnt;

  sram_arb_mux #(.AW(AW), .NUM_PORTS(2)) u_mux (
    .gnt   (gnt),
    .m_adr ({m1_adr_i, m0_adr_i}),
    .m_dat ({m1_dat_i, m0_dat_i}),
    .m_sel ({m1_sel_i, m0_sel_i}),
    .m_we  ({m1_we_i,  m0_we_i}),
    .m_stb ({m1_stb_i, m0_stb_i}),
    .m_cyc ({m1_cyc_i, m0_cyc_i}),
    .s_ack (s_ack_i),
    .m_ack (ack),
    .s_adr (s_adr_o),
    .s_dat (s_dat_o),
    .s_sel (s_sel_o),
    .s_we  (s_we_o),
    .s_stb (s_stb_o),
    .s_cyc (s_cyc_o)
  );

  // Read data fans out to both masters; only the acked one samples it
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack[0];
  assign m1_ack_o = ack[1];

endmodule
